// File: rtl/instr_encoder_pkg.sv
// Shared types for the instruction encoder: format select, opcodes, field bundle,
// FSM states and the immediate range limits used by the optional range check.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_J   = 3'd5,
    FMT_U   = 3'd6
  } fmt_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -(1 << 20);
  localparam int IMMJ_MAX  = (1 << 20) - 2;
  localparam int SHAMT_MIN = 0;
  localparam int SHAMT_MAX = 31;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder; slave is the encoder side,
// master is the producer/consumer side.
interface instr_encoder_if
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) ();
  logic              in_valid;
  logic              in_ready;
  fmt_e              fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W+1:0] out_addr;
  logic              err;
  logic              clr_err;

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready, clr_err,
    output in_ready, out_valid, out_instr, out_addr, err
  );

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready, clr_err,
    input  in_ready, out_valid, out_instr, out_addr, err
  );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: places fields into the 32-bit word for the selected format.
// With ENC_RANGE_CHECK_EN the immediate is also range-checked; otherwise it is truncated.
module imm_pack
  import instr_encoder_pkg::*;
(
  input  fmt_e        fmt,
  input  fields_t     f,
  output logic [31:0] word,
  output logic        range_fault
);
  logic signed [31:0] simm;

  always_comb begin
    word        = '0;
    range_fault = 1'b0;
    simm        = $signed(f.imm);
    case (fmt)
      FMT_I:   word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_ISH: word = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S:   word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_B:   word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                       f.imm[4:1], f.imm[11], f.opcode};
      FMT_J:   word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      FMT_U:   word = {f.imm[31:12], f.rd, f.opcode};
      default: word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
    endcase
`ifdef ENC_RANGE_CHECK_EN
    // Branch/jump offsets are byte offsets to 2-byte aligned targets, so odd is illegal.
    case (fmt)
      FMT_I, FMT_S: range_fault = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      FMT_ISH:      range_fault = (simm < SHAMT_MIN) || (simm > SHAMT_MAX);
      FMT_B:        range_fault = (simm < IMMB_MIN) || (simm > IMMB_MAX) || f.imm[0];
      FMT_J:        range_fault = (simm < IMMJ_MIN) || (simm > IMMJ_MAX) || f.imm[0];
      FMT_U:        range_fault = (f.imm[11:0] != 12'd0);
      default:      range_fault = 1'b0;
    endcase
`endif
  end
endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: registered output, latency 1, accept-and-drain without bubbles,
// output held under backpressure. ENC_RANGE_CHECK_EN enables the sticky range fault.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);
  fields_t           fields;
  logic [31:0]       enc_word;
  logic              enc_fault;
  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_ready;
  logic              accept;
  logic              drain;

  always_comb begin
    fields        = '0;
    fields.opcode = bus.opcode;
    fields.rd     = bus.rd;
    fields.rs1    = bus.rs1;
    fields.rs2    = bus.rs2;
    fields.funct3 = bus.funct3;
    fields.funct7 = bus.funct7;
    fields.imm    = bus.imm;
  end

  imm_pack u_imm_pack (
    .fmt         (bus.fmt),
    .f           (fields),
    .word        (enc_word),
    .range_fault (enc_fault)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    addr_d      = addr_q;
    in_ready    = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    accept      = bus.in_valid && in_ready;
    drain       = out_valid_q && bus.out_ready;
    if (drain) begin
      out_valid_d = 1'b0;
      addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
    case (state_q)
      ST_RUN: begin
        // A faulting request never reaches the output register.
        if (accept) begin
          if (enc_fault) begin
            state_d = ST_FAULT;
          end else begin
            out_valid_d = 1'b1;
            out_instr_d = enc_word;
          end
        end
      end
      ST_FAULT: if (bus.clr_err) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      addr_q      <= addr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = {addr_q, 2'b00};
`ifdef ENC_RANGE_CHECK_EN
  assign bus.err = (state_q == ST_FAULT);
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 2-bit word counter so address wrap is reached.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  instr_encoder_if #(.ADDR_W(2)) bus ();

  instr_encoder #(.ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input fmt_e f, input logic [6:0] opc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    bus.fmt      = f;
    bus.opcode   = opc;
    bus.rd       = rd;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.fmt       = FMT_R;
    bus.opcode    = '0;
    bus.rd        = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.funct3    = '0;
    bus.funct7    = '0;
    bus.imm       = '0;
    bus.out_ready = 1'b1;
    bus.clr_err   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // addi x1, x0, 5
    set_req(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    check("i_valid", 32'(bus.out_valid), 32'd1);
    check("i_instr", bus.out_instr, 32'h00500093);
    check("i_addr", 32'(bus.out_addr), 32'd0);

    // sw x2, 8(x1), back-to-back with the drain of the previous word
    set_req(FMT_S, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    step();
    check("s_instr", bus.out_instr, 32'h0020A423);
    check("s_addr", 32'(bus.out_addr), 32'd4);
    bus.in_valid = 1'b0;
    step();
    check("s_drained", 32'(bus.out_valid), 32'd0);

    // jal x1, 8 then beq x0, x0, -4 with no bubble
    set_req(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    step();
    check("j_instr", bus.out_instr, 32'h008000EF);
    check("j_addr", 32'(bus.out_addr), 32'd8);
    set_req(FMT_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    step();
    check("b_valid", 32'(bus.out_valid), 32'd1);
    check("b_instr", bus.out_instr, 32'hFE000EE3);
    check("b_addr", 32'(bus.out_addr), 32'd12);
    bus.in_valid = 1'b0;
    step();
    check("b_drained", 32'(bus.out_valid), 32'd0);
    check("addr_wrap", 32'(bus.out_addr), 32'd0);

    // Backpressure: sub x1, x2, x3 held while lui x5, 0x12345 waits
    bus.out_ready = 1'b0;
    set_req(FMT_R, OPC_OP, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
    step();
    check("r_instr", bus.out_instr, 32'h403100B3);
    set_req(FMT_U, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_instr", bus.out_instr, 32'h403100B3);
      check("bp_addr", 32'(bus.out_addr), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("u_instr", bus.out_instr, 32'h123452B7);
    check("u_addr", 32'(bus.out_addr), 32'd4);

    // slli x1, x1, 3
    set_req(FMT_ISH, OPC_OP_IMM, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd3);
    step();
    check("ish_instr", bus.out_instr, 32'h00309093);
    check("ish_addr", 32'(bus.out_addr), 32'd8);
    bus.in_valid = 1'b0;
    step();
    check("ish_drained", 32'(bus.out_valid), 32'd0);
    check("ish_next_addr", 32'(bus.out_addr), 32'd12);

    // Out-of-range I immediate
    set_req(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    step();
`ifdef ENC_RANGE_CHECK_EN
    check("fault_err", 32'(bus.err), 32'd1);
    check("fault_in_ready", 32'(bus.in_ready), 32'd0);
    check("fault_no_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    step();
    check("fault_sticky", 32'(bus.err), 32'd1);
    check("fault_no_valid2", 32'(bus.out_valid), 32'd0);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    check("clr_err", 32'(bus.err), 32'd0);
    check("clr_in_ready", 32'(bus.in_ready), 32'd1);
    check("fault_addr_kept", 32'(bus.out_addr), 32'd12);
`else
    check("trunc_err", 32'(bus.err), 32'd0);
    check("trunc_valid", 32'(bus.out_valid), 32'd1);
    check("trunc_instr", bus.out_instr, 32'h80000093);
    check("trunc_addr", 32'(bus.out_addr), 32'd12);
    bus.in_valid = 1'b0;
    step();
    check("trunc_wrap", 32'(bus.out_addr), 32'd0);
`endif

    // Reset while a word is pending discards it
    bus.out_ready = 1'b0;
    set_req(FMT_I, OPC_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    step();
    check("pend_valid", 32'(bus.out_valid), 32'd1);
    check("pend_instr", bus.out_instr, 32'h00700113);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("pend_rst_valid", 32'(bus.out_valid), 32'd0);
    check("pend_rst_instr", bus.out_instr, 32'h0);
    check("pend_rst_addr", 32'(bus.out_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_addr", 32'(bus.out_addr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
